dout_capture_fifo: RTL and testbench

- Sits directly downstream of rv_cpu_top and consumes its 32-bit Data_out bus (LFSR sequence output).
- Detects each new value on the bus and pushes it into a small synchronous FIFO.
- A valid/ready drain port lets a checker, or a later UART or host stage, read the sequence without losing values.
- Keeps a sticky overflow flag and a saturating count of accepted samples, for sequence-length checks.

---
 rtl/dout_capture_fifo.sv | 123 ++++++++++++
 tb/tb_dout_capture_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dout_capture_fifo.sv
// Captures each new value seen on the upstream Data_out bus into a small FIFO
// with a valid/ready drain port, a sticky overflow flag and a saturating sample count.
module dout_capture_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              capture_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [DATA_W-1:0] prev_q;
  logic              armed;

  logic              full;
  logic              pop;
  logic              push_req;
  logic              push_ok;
  logic              drop;
  logic [ADDR_W:0]   level_nxt;
  logic [DATA_W-1:0] m_data_nxt;

  assign full     = (level == LVL_FULL);
  assign pop      = m_valid & m_ready;
  assign push_req = capture_en & (~armed | (data_in != prev_q));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    level_nxt = level;
    case ({push_ok, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // The entry being written this cycle becomes the head only when it lands on
  // rd_ptr_nxt, so bypass it straight into the output register.
  always_comb begin
    m_data_nxt = mem[rd_ptr_nxt];
    if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
      m_data_nxt = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      armed  <= 1'b0;
    end else if (capture_en) begin
      prev_q <= data_in;
      armed  <= 1'b1;
    end else begin
      armed  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= data_in;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      level   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      level   <= level_nxt;
      m_valid <= (level_nxt != '0);
      m_data  <= m_data_nxt;
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt <= '0;
    end else if (push_ok && (sample_cnt != '1)) begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dout_capture_fifo.sv
// Directed bench for dout_capture_fifo: change detection, ordering, overflow,
// full-with-pop, async reset, enable re-arm and an LFSR stream against a queue model.
module tb_dout_capture_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        capture_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] sample_cnt;

  int n_cmp = 0;
  int n_err = 0;

  dout_capture_fifo #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .capture_en (capture_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .sample_cnt (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain_check(input string tag, input logic [31:0] exp_list[$]);
    m_ready = 1'b1;
    foreach (exp_list[i]) begin
      chk(tag, {32'h0, m_data}, {32'h0, exp_list[i]});
      tick();
    end
    m_ready = 1'b0;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] lfsr;
  logic [31:0] last_v;
  int          guard;

  initial begin
    rst = 1'b0; data_in = '0; capture_en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    tick(3);
    chk("rst_valid",  m_valid, 0);
    chk("rst_level",  level, 0);
    chk("rst_ovf",    overflow, 0);
    chk("rst_cnt",    sample_cnt, 0);
    chk("rst_data",   m_data, 0);
    rst = 1'b1;
    tick();

    // Held value pushes exactly once; 1-cycle latency to m_valid
    capture_en = 1'b1; data_in = 32'h1;
    tick();
    chk("lat_valid", m_valid, 1);
    tick(4);
    chk("hold_level", level, 1);
    chk("hold_data",  m_data, 32'h1);
    chk("hold_valid", m_valid, 1);
    chk("hold_cnt",   sample_cnt, 1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("pop1_level", level, 0);
    chk("pop1_valid", m_valid, 0);

    // Repeated value is filtered out
    capture_en = 1'b0; tick();
    capture_en = 1'b1;
    data_in = 32'h1; tick();
    data_in = 32'h2; tick();
    data_in = 32'h2; tick();
    data_in = 32'h3; tick();
    data_in = 32'h1; tick();
    capture_en = 1'b0; tick();
    chk("seq_level", level, 4);
    chk("seq_cnt",   sample_cnt, 5);
    drain_check("seq_drain", '{32'h1, 32'h2, 32'h3, 32'h1});
    chk("seq_empty", level, 0);

    // Overflow with 10 distinct values
    capture_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 32'h100 + 32'(i);
      tick();
    end
    capture_en = 1'b0; tick();
    chk("ovf_level", level, 8);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_cnt",   sample_cnt, 13);
    chk("ovf_head",  m_data, 32'h100);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Drop and clear in the same cycle: set wins
    capture_en = 1'b1; data_in = 32'h200; clr_ovf = 1'b1; tick();
    capture_en = 1'b0; clr_ovf = 1'b0;
    chk("setwin_ovf", overflow, 1);
    chk("setwin_cnt", sample_cnt, 13);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("setwin_clr", overflow, 0);

    // Full with simultaneous pop and push
    capture_en = 1'b1; data_in = 32'hDEAD_BEEF; m_ready = 1'b1; tick();
    capture_en = 1'b0; m_ready = 1'b0;
    chk("fullpop_ovf",   overflow, 0);
    chk("fullpop_level", level, 8);
    chk("fullpop_cnt",   sample_cnt, 14);
    drain_check("fullpop_drain", '{32'h101, 32'h102, 32'h103, 32'h104,
                                   32'h105, 32'h106, 32'h107, 32'hDEAD_BEEF});
    chk("fullpop_empty", m_valid, 0);

    // Async reset mid-cycle with level=5
    capture_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 32'h300 + 32'(i);
      tick();
    end
    chk("prerst_level", level, 5);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_cnt",   sample_cnt, 0);
    tick(); rst = 1'b1; tick();
    chk("rearm_level", level, 1);
    chk("rearm_data",  m_data, 32'h304);
    chk("rearm_cnt",   sample_cnt, 1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;

    // Enable toggle with constant data
    capture_en = 1'b0; tick();
    data_in = 32'h55;
    capture_en = 1'b1; tick(3);
    capture_en = 1'b0; tick(2);
    capture_en = 1'b1; tick(3);
    capture_en = 1'b0; tick();
    chk("en_cnt",   sample_cnt, 3);
    chk("en_level", level, 2);
    drain_check("en_drain", '{32'h55, 32'h55});

    // Free-running LFSR with continuous drain
    lfsr = 32'hACE1_2345; last_v = 32'h55;
    m_ready = 1'b1; capture_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_valid) begin
        if (exp_q.size() == 0) chk("lfsr_unexpected", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("lfsr_data", m_data, exp_q.pop_front());
      end
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      data_in = lfsr;
      if (i == 0 || lfsr != last_v) exp_q.push_back(lfsr);
      last_v = lfsr;
      tick();
    end
    capture_en = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      if (m_valid) chk("lfsr_tail", m_data, exp_q.pop_front());
      guard++;
      tick();
    end
    chk("lfsr_left",  exp_q.size(), 0);
    chk("lfsr_ovf",   overflow, 0);
    chk("lfsr_level", level, 0);
    chk("lfsr_cnt",   sample_cnt, 103);
    m_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
